// File: rtl/async_fifo_pkg.sv
// Shared constants and pointer-code helpers for the async FIFO write/read controllers.
package async_fifo_pkg;

    localparam int ADDR_WIDTH_DEF = 4;
    localparam int DEPTH_DEF      = 1 << ADDR_WIDTH_DEF;
    localparam int PTR_W_DEF      = ADDR_WIDTH_DEF + 1;

    typedef struct packed {
        logic full;
        logic afull;
        logic ovf;
    } wflags_t;

    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    // Each binary bit is the XOR of its Gray bit and every Gray bit above it.
    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b = g;
        for (int s = 1; s < 32; s++) begin
            b = b ^ (g >> s);
        end
        return b;
    endfunction

endpackage

// File: rtl/gray2binary.sv
// Converts a Gray-coded pointer to plain binary.
module gray2binary
    import async_fifo_pkg::*;
#(
    parameter int WIDTH = 5
) (
    input  logic [WIDTH-1:0] gray_i,
    output logic [WIDTH-1:0] bin_o
);

    // Pure conversion, no state.
    always_comb begin
        bin_o = WIDTH'(gray2bin(32'(gray_i)));
    end

endmodule

// File: rtl/async_fifo_wptr_ctrl.sv
// Write-domain pointer controller: binary/Gray write pointer, full/almost-full,
// write-side occupancy and a sticky overflow flag.
module async_fifo_wptr_ctrl
    import async_fifo_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                  wclk,
    input  logic                  wrst_n,
    input  logic [ADDR_WIDTH:0]   wq2_rptr,
    input  logic                  wpush,
    input  logic [ADDR_WIDTH:0]   afull_level,
    input  logic                  woverflow_clr,
    output logic [ADDR_WIDTH:0]   wptr,
    output logic [ADDR_WIDTH-1:0] waddr,
    output logic                  wen,
    output logic                  wfull,
    output logic                  walmost_full,
    output logic [ADDR_WIDTH:0]   wlevel,
    output logic                  woverflow
);

    localparam int PTR_W = ADDR_WIDTH + 1;
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [PTR_W-1:0] DEPTH_V = PTR_W'(DEPTH);

    logic [PTR_W-1:0] wbin_q, wbin_d;
    logic [PTR_W-1:0] wgray_q, wgray_d;
    logic [PTR_W-1:0] wlevel_q, wlevel_d;
    logic [PTR_W-1:0] rbin_s;
    wflags_t          flags_q, flags_d;
    logic             acc_s;

    gray2binary #(
        .WIDTH (PTR_W)
    ) u_rptr_g2b (
        .gray_i (wq2_rptr),
        .bin_o  (rbin_s)
    );

    // Next pointer, occupancy and flags; full is judged on the post-push level.
    always_comb begin
        acc_s         = wpush & ~flags_q.full;
        wbin_d        = wbin_q + {{(PTR_W-1){1'b0}}, acc_s};
        wgray_d       = PTR_W'(bin2gray(32'(wbin_d)));
        wlevel_d      = wbin_d - rbin_s;
        flags_d.full  = (wlevel_d == DEPTH_V);
        flags_d.afull = (wlevel_d >= afull_level);
        if (wpush & flags_q.full) begin
            flags_d.ovf = 1'b1;
        end else if (woverflow_clr) begin
            flags_d.ovf = 1'b0;
        end else begin
            flags_d.ovf = flags_q.ovf;
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge wclk) begin
        if (!wrst_n) begin
            wbin_q   <= {PTR_W{1'b0}};
            wgray_q  <= {PTR_W{1'b0}};
            wlevel_q <= {PTR_W{1'b0}};
            flags_q  <= '{full: 1'b0, afull: 1'b0, ovf: 1'b0};
        end else begin
            wbin_q   <= wbin_d;
            wgray_q  <= wgray_d;
            wlevel_q <= wlevel_d;
            flags_q  <= flags_d;
        end
    end

    assign wptr         = wgray_q;
    assign waddr        = wbin_q[ADDR_WIDTH-1:0];
    assign wen          = acc_s & wrst_n;
    assign wfull        = flags_q.full;
    assign walmost_full = flags_q.afull;
    assign wlevel       = wlevel_q;
    assign woverflow    = flags_q.ovf;

endmodule

// File: tb/tb_async_fifo_wptr_ctrl.sv
// Randomized/directed bench for async_fifo_wptr_ctrl with a count-based reference model.
module tb_async_fifo_wptr_ctrl;

    logic       wclk;
    logic       wrst_n;
    logic [2:0] wq2_rptr;
    logic       wpush;
    logic [2:0] afull_level;
    logic       woverflow_clr;
    logic [2:0] wptr;
    logic [1:0] waddr;
    logic       wen;
    logic       wfull;
    logic       walmost_full;
    logic [2:0] wlevel;
    logic       woverflow;

    int total = 0;
    int bad   = 0;

    // Model: total accepted writes and total reads as plain integers.
    int wr_cnt = 0;
    int rd_cnt = 0;
    int m_level = 0;
    bit m_full = 1'b0;
    bit m_afull = 1'b0;
    bit m_ovf = 1'b0;
    int afl = 3;

    async_fifo_wptr_ctrl #(.ADDR_WIDTH(2)) dut (
        .wclk          (wclk),
        .wrst_n        (wrst_n),
        .wq2_rptr      (wq2_rptr),
        .wpush         (wpush),
        .afull_level   (afull_level),
        .woverflow_clr (woverflow_clr),
        .wptr          (wptr),
        .waddr         (waddr),
        .wen           (wen),
        .wfull         (wfull),
        .walmost_full  (walmost_full),
        .wlevel        (wlevel),
        .woverflow     (woverflow)
    );

    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    function automatic logic [2:0] g3(input int v);
        logic [2:0] b;
        b = 3'(v % 8);
        return b ^ (b >> 1);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at posedge+1; checks combinational outputs at the negedge and
    // registered outputs just after the next posedge.
    task automatic cycle(input logic push, input int rd, input logic clr);
        bit acc;
        logic [2:0] rq;
        wpush = push;
        woverflow_clr = clr;
        rd_cnt = rd;
        rq = g3(rd);
        wq2_rptr = rq;
        afull_level = 3'(afl);
        acc = push && !m_full;
        #4;
        chk("wen", 32'(wen), 32'(acc));
        chk("waddr", 32'(waddr), 32'(wr_cnt % 4));
        if (push && m_full) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
        else m_ovf = m_ovf;
        wr_cnt += int'(acc);
        m_level = wr_cnt - rd_cnt;
        m_full = (m_level == 4);
        m_afull = (m_level >= afl);
        @(posedge wclk);
        #1;
        chk("wptr", 32'(wptr), 32'(g3(wr_cnt)));
        chk("wlevel", 32'(wlevel), 32'(m_level));
        chk("wfull", 32'(wfull), 32'(m_full));
        chk("walmost_full", 32'(walmost_full), 32'(m_afull));
        chk("woverflow", 32'(woverflow), 32'(m_ovf));
        chk("level_max", 32'(wlevel <= 3'd4), 32'd1);
        chk("gray_full_eq", 32'(wfull), 32'(g3(wr_cnt) == {~rq[2:1], rq[0]}));
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            wrst_n = 1'b0;
            wpush = 1'b1;
            woverflow_clr = 1'b0;
            wq2_rptr = 3'd0;
            afull_level = 3'(afl);
            #4;
            chk("rst_wen", 32'(wen), 32'd0);
            @(posedge wclk);
            #1;
            chk("rst_wptr", 32'(wptr), 32'd0);
            chk("rst_waddr", 32'(waddr), 32'd0);
            chk("rst_wfull", 32'(wfull), 32'd0);
            chk("rst_afull", 32'(walmost_full), 32'd0);
            chk("rst_wlevel", 32'(wlevel), 32'd0);
            chk("rst_ovf", 32'(woverflow), 32'd0);
        end
        wrst_n = 1'b1;
        wr_cnt = 0;
        rd_cnt = 0;
        m_level = 0;
        m_full = 1'b0;
        m_afull = 1'b0;
        m_ovf = 1'b0;
    endtask

    initial begin
        wrst_n = 1'b0;
        wpush = 1'b0;
        woverflow_clr = 1'b0;
        wq2_rptr = 3'd0;
        afull_level = 3'd3;
        @(posedge wclk);
        #1;

        // Reset with push held high, then fill four entries.
        afl = 3;
        do_reset(3);
        for (int i = 0; i < 4; i++) cycle(1'b1, 0, 1'b0);
        chk("fill_wptr", 32'(wptr), 32'd6);

        // Overflow: rejected push, stickiness, set-beats-clear, then clear.
        cycle(1'b1, 0, 1'b0);
        cycle(1'b0, 0, 1'b0);
        cycle(1'b1, 0, 1'b1);
        cycle(1'b0, 0, 1'b1);

        // Drain two entries by advancing the read pointer.
        cycle(1'b0, 1, 1'b0);
        cycle(1'b0, 2, 1'b0);

        // Wrap: read pointer trails by two while streaming pushes.
        for (int i = 0; i < 20; i++) cycle(1'b1, rd_cnt + 1, 1'b0);

        // Random traffic with a mid-operation reset between segments.
        for (int seg = 0; seg < 3; seg++) begin
            afl = int'($urandom_range(0, 5));
            for (int i = 0; i < 60; i++) begin
                int nrd;
                nrd = rd_cnt;
                if (rd_cnt < wr_cnt && $urandom_range(0, 1) == 1) nrd = rd_cnt + 1;
                cycle(1'($urandom_range(0, 1)), nrd, 1'($urandom_range(0, 7) == 0));
            end
            do_reset(1);
        end

        // Threshold edges: zero means always set, above depth means never set.
        afl = 0;
        do_reset(1);
        cycle(1'b0, 0, 1'b0);
        chk("afl0_empty", 32'(walmost_full), 32'd1);
        afl = 5;
        do_reset(1);
        for (int i = 0; i < 6; i++) cycle(1'b1, 0, 1'b0);
        chk("afl5_full", 32'(walmost_full), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
